// File: rtl/picomips_pkg.sv
// Shared types and widths for the picoMIPS front-end blocks.
package picomips_pkg;
    localparam int SW_W   = 10;
    localparam int DATA_W = 8;

    typedef enum logic {IDLE, VALID} swc_state_t;
endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by an optional debounce filter.
// Filter present only when SWCOND_DEBOUNCE_EN is defined; otherwise clean = synchroniser output.
module sw_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef SWCOND_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          clean_q;

    // Any cycle where the synchronised level agrees with clean restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clean_q <= 1'b0;
        end else if (s2 != clean_q) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
                clean_q <= s2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign clean = clean_q;
`else
    assign clean = s2;
`endif
endmodule

// File: rtl/sw_conditioner.sv
// Switch conditioner: per-bit sync/debounce, strobe-triggered capture with valid/ready and sticky overrun.
// Debounce counters are built only when SWCOND_DEBOUNCE_EN is defined.
module sw_conditioner
    import picomips_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int STROBE_BIT = 8,
    parameter int CLEAR_BIT  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   sw_in,
    output logic [SW_W-1:0]   sw_clean,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun
);
    swc_state_t        state;
    swc_state_t        state_nx;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_nx;
    logic              ovr_q;
    logic              ovr_nx;
    logic              ovr_set;
    logic              strobe_prev;
    logic              strobe;

    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_in[i]),
            .clean (sw_clean[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev <= 1'b0;
            state       <= IDLE;
            data_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            strobe_prev <= sw_clean[STROBE_BIT];
            state       <= state_nx;
            data_q      <= data_nx;
            ovr_q       <= ovr_nx;
        end
    end

    assign strobe = sw_clean[STROBE_BIT] & ~strobe_prev;

    always_comb begin
        state_nx = state;
        data_nx  = data_q;
        ovr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    data_nx  = sw_clean[DATA_W-1:0];
                    state_nx = VALID;
                end
            end
            VALID: begin
                // Unconsumed word is kept on a collision; the newer capture is the one dropped.
                if (strobe) begin
                    if (data_ready) data_nx = sw_clean[DATA_W-1:0];
                    else            ovr_set = 1'b1;
                end else if (data_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        ovr_nx = ovr_q;
        if (ovr_set)                  ovr_nx = 1'b1;
        else if (sw_clean[CLEAR_BIT]) ovr_nx = 1'b0;
    end

    assign data_out   = data_q;
    assign data_valid = (state == VALID);
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner; accepted words are checked by a scoreboard monitor.
module tb_sw_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw_in = '0;
    logic [9:0] sw_clean;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

`ifdef SWCOND_DEBOUNCE_EN
    localparam int LAT = 4 + 2;
`else
    localparam int LAT = 2;
`endif

    sw_conditioner #(.DB_CYCLES(4), .STROBE_BIT(8), .CLEAR_BIT(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .sw_clean   (sw_clean),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_sw_clean"}, 32'(sw_clean), 0);
        chk({name, "_data_out"}, 32'(data_out), 0);
        chk({name, "_data_valid"}, 32'(data_valid), 0);
        chk({name, "_overrun"}, 32'(overrun), 0);
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_unexpected: got %0h, expected no word", data_out);
            end else begin
                chk("accept_word", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tick(3);
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        tick(10);
        chk_all_zero("after_release");

        // Debounce accept on bit 3
        sw_in[3] = 1'b1;
        tick(LAT - 1);
        chk("accept_before", 32'(sw_clean[3]), 0);
        tick(1);
        chk("accept_at", 32'(sw_clean[3]), 1);
        sw_in[3] = 1'b0;
        tick(LAT + 2);
        chk("accept_release", 32'(sw_clean[3]), 0);

        // Three-cycle glitch on bit 3
        sw_in[3] = 1'b1;
        tick(2);
`ifdef SWCOND_DEBOUNCE_EN
        chk("glitch_mid", 32'(sw_clean[3]), 0);
`else
        chk("glitch_mid", 32'(sw_clean[3]), 1);
`endif
        tick(1);
        sw_in[3] = 1'b0;
        tick(8);
        chk("glitch_end", 32'(sw_clean[3]), 0);

        // Capture A5 and hand it off
        sw_in[7:0] = 8'hA5;
        tick(LAT + 2);
        sw_in[8] = 1'b1;
        exp_q.push_back(8'hA5);
        tick(LAT);
        chk("capture_before", 32'(data_valid), 0);
        tick(1);
        chk("capture_valid", 32'(data_valid), 1);
        chk("capture_data", 32'(data_out), 32'h A5);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("handoff_valid", 32'(data_valid), 0);
        sw_in[8] = 1'b0;
        tick(LAT + 2);

        // Overrun: second strobe while A5 is unconsumed
        sw_in[8] = 1'b1;
        exp_q.push_back(8'hA5);
        tick(LAT + 1);
        chk("ovr_first_valid", 32'(data_valid), 1);
        sw_in[8] = 1'b0;
        tick(LAT + 2);
        sw_in[7:0] = 8'h3C;
        tick(LAT + 2);
        sw_in[8] = 1'b1;
        tick(LAT);
        chk("ovr_before", 32'(overrun), 0);
        tick(1);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_data_kept", 32'(data_out), 32'hA5);
        chk("ovr_still_valid", 32'(data_valid), 1);
        sw_in[9] = 1'b1;
        tick(LAT);
        chk("ovr_before_clear", 32'(overrun), 1);
        tick(1);
        chk("ovr_cleared", 32'(overrun), 0);
        sw_in[9] = 1'b0;
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("ovr_drain_valid", 32'(data_valid), 0);
        sw_in[8] = 1'b0;
        tick(LAT + 2);

        // Capture 3C, then collide a 5A strobe with data_ready
        sw_in[8] = 1'b1;
        exp_q.push_back(8'h3C);
        tick(LAT + 1);
        chk("sim_first_data", 32'(data_out), 32'h3C);
        sw_in[8] = 1'b0;
        tick(LAT + 2);
        sw_in[7:0] = 8'h5A;
        tick(LAT + 2);
        sw_in[8] = 1'b1;
        exp_q.push_back(8'h5A);
        tick(LAT);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("sim_valid", 32'(data_valid), 1);
        chk("sim_data", 32'(data_out), 32'h5A);
        chk("sim_overrun", 32'(overrun), 0);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("sim_drain_valid", 32'(data_valid), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        // Reset mid-operation with a word pending and overrun set
        sw_in[8] = 1'b0;
        tick(LAT + 2);
        sw_in[8] = 1'b1;
        tick(LAT + 1);
        sw_in[8] = 1'b0;
        tick(LAT + 2);
        sw_in[8] = 1'b1;
        tick(LAT + 1);
        chk("pre_reset_overrun", 32'(overrun), 1);
        sw_in[3] = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        sw_in = '0;
        #3;
        rst_n = 1'b1;
        tick(12);
        chk_all_zero("after_mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
